// File: rtl/pippenger_bucket_reduce.sv
// Running-sum bucket reduction for one Pippenger window: R = sum_j j*B[j].
// Toy curve y^2 = x^3 + 2x + b over GF(251); one shared multi-cycle affine point adder.

package pippenger_pkg;
  localparam logic [7:0] FIELD_P = 8'd251;
  localparam logic [7:0] CURVE_A = 8'd2;

  typedef struct packed {
    logic       inf;
    logic [7:0] x;
    logic [7:0] y;
  } curve_point_t;

  localparam curve_point_t INF_POINT = '{inf: 1'b1, x: 8'd0, y: 8'd0};

  function automatic logic [7:0] mod_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, FIELD_P}) ? 8'(s - {1'b0, FIELD_P}) : s[7:0];
  endfunction

  function automatic logic [7:0] mod_sub(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : 8'({1'b0, a} + {1'b0, FIELD_P} - {1'b0, b});
  endfunction

  function automatic logic [7:0] mod_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, a} * {8'd0, b};
    return 8'(prod % {8'd0, FIELD_P});
  endfunction
endpackage

// Affine point adder. Reset is an active-high start pulse that latches P/Q;
// the slope denominator is inverted by Fermat exponentiation, one bit per cycle.
module point_add
  import pippenger_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         Reset,
  input  curve_point_t P,
  input  curve_point_t Q,
  output curve_point_t R,
  output logic         Done
);
  typedef enum logic [1:0] {ADD_IDLE, ADD_INV, ADD_FIN} add_state_t;

  localparam logic [7:0] INV_EXP = FIELD_P - 8'd2;

  add_state_t   state_q, state_d;
  logic [7:0]   x1_q, x1_d, y1_q, y1_d, x2_q, x2_d;
  logic [7:0]   num_q, num_d, base_q, base_d, inv_q, inv_d;
  logic [2:0]   bit_q, bit_d;
  curve_point_t r_q, r_d;
  logic         done_q, done_d;
  logic [7:0]   lam, x3, y3;

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    num_d   = num_q;
    base_d  = base_q;
    inv_d   = inv_q;
    bit_d   = bit_q;
    r_d     = r_q;
    done_d  = done_q;
    lam     = mod_mul(num_q, inv_q);
    x3      = mod_sub(mod_sub(mod_mul(lam, lam), x1_q), x2_q);
    y3      = mod_sub(mod_mul(lam, mod_sub(x1_q, x3)), y1_q);

    if (Reset) begin
      x1_d    = P.x;
      y1_d    = P.y;
      x2_d    = Q.x;
      inv_d   = 8'd1;
      bit_d   = 3'd0;
      done_d  = 1'b0;
      state_d = ADD_INV;
      // Degenerate operand pairs resolve without the inversion pass.
      if (P.inf) begin
        r_d = Q; done_d = 1'b1; state_d = ADD_IDLE;
      end else if (Q.inf) begin
        r_d = P; done_d = 1'b1; state_d = ADD_IDLE;
      end else if (P.x == Q.x && mod_add(P.y, Q.y) == 8'd0) begin
        r_d = INF_POINT; done_d = 1'b1; state_d = ADD_IDLE;
      end else if (P.x == Q.x) begin
        num_d  = mod_add(mod_mul(8'd3, mod_mul(P.x, P.x)), CURVE_A);
        base_d = mod_add(P.y, P.y);
      end else begin
        num_d  = mod_sub(Q.y, P.y);
        base_d = mod_sub(Q.x, P.x);
      end
    end else begin
      case (state_q)
        ADD_INV: begin
          if (INV_EXP[bit_q]) inv_d = mod_mul(inv_q, base_q);
          base_d = mod_mul(base_q, base_q);
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ADD_FIN;
        end
        ADD_FIN: begin
          r_d.inf = 1'b0;
          r_d.x   = x3;
          r_d.y   = y3;
          done_d  = 1'b1;
          state_d = ADD_IDLE;
        end
        default: state_d = ADD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ADD_IDLE;
      x1_q    <= 8'd0;
      y1_q    <= 8'd0;
      x2_q    <= 8'd0;
      num_q   <= 8'd0;
      base_q  <= 8'd0;
      inv_q   <= 8'd0;
      bit_q   <= 3'd0;
      r_q     <= INF_POINT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      num_q   <= num_d;
      base_q  <= base_d;
      inv_q   <= inv_d;
      bit_q   <= bit_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign R    = r_q;
  assign Done = done_q;
endmodule

module pippenger_bucket_reduce
  import pippenger_pkg::*;
#(
  parameter int C = 4
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  curve_point_t [(2**C)-1:1] B,
  output logic                     Busy,
  output logic                     Done,
  output curve_point_t             R
);
  typedef enum logic [1:0] {IDLE, RUN_ACC, RUN_SUM, DONE} state_t;

  localparam logic [C-1:0] J_MAX = '1;

  state_t       state_q, state_d;
  logic [C-1:0] j_q, j_d;
  curve_point_t acc_q, acc_d, sum_q, sum_d, r_q, r_d;
  logic         wait_q, wait_d;
  curve_point_t b_sel, op_a, op_b, step_res, add_r;
  logic         add_go, add_done, step_done;

  assign b_sel = B[j_q];

  // Both run states share one step engine; only the operand pair and destination differ.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    r_d       = r_q;
    wait_d    = wait_q;
    add_go    = 1'b0;
    step_done = 1'b0;
    step_res  = INF_POINT;
    op_a      = (state_q == RUN_SUM) ? sum_q : acc_q;
    op_b      = (state_q == RUN_SUM) ? acc_q : b_sel;

    if (state_q == RUN_ACC || state_q == RUN_SUM) begin
      if (!wait_q) begin
        if (op_a.inf) begin
          step_done = 1'b1;
          step_res  = op_b;
        end else if (op_b.inf) begin
          step_done = 1'b1;
          step_res  = op_a;
        end else begin
          add_go = 1'b1;
          wait_d = 1'b1;
        end
      end else if (add_done) begin
        step_done = 1'b1;
        step_res  = add_r;
        wait_d    = 1'b0;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          j_d     = J_MAX;
          acc_d   = INF_POINT;
          sum_d   = INF_POINT;
          wait_d  = 1'b0;
          state_d = RUN_ACC;
        end
      end
      RUN_ACC: begin
        if (step_done) begin
          acc_d   = step_res;
          state_d = RUN_SUM;
        end
      end
      RUN_SUM: begin
        if (step_done) begin
          sum_d = step_res;
          if (j_q == C'(1)) begin
            r_d     = step_res;
            state_d = DONE;
          end else begin
            j_d     = j_q - C'(1);
            state_d = RUN_ACC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      j_q     <= J_MAX;
      acc_q   <= INF_POINT;
      sum_q   <= INF_POINT;
      r_q     <= INF_POINT;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      r_q     <= r_d;
      wait_q  <= wait_d;
    end
  end

  point_add u_add (
    .clk   (clk),
    .rst_n (Reset),
    .Reset (add_go),
    .P     (op_a),
    .Q     (op_b),
    .R     (add_r),
    .Done  (add_done)
  );

  assign Busy = (state_q == RUN_ACC) || (state_q == RUN_SUM);
  assign Done = (state_q == DONE);
  assign R    = r_q;
endmodule

// File: tb/tb_pippenger_bucket_reduce.sv
// Randomized bench for pippenger_bucket_reduce: window sums checked against
// scalar multiplication of a generator computed with plain integer field arithmetic.

module tb_pippenger_bucket_reduce;
  import pippenger_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start2, start4;
  curve_point_t [3:1]  b2;
  curve_point_t [15:1] b4;
  logic busy2, done2, busy4, done4;
  curve_point_t r2, r4;

  int tests_run    = 0;
  int tests_failed = 0;
  int starts2      = 0;
  curve_point_t g;

  pippenger_bucket_reduce #(.C(2)) dut2 (
    .clk(clk), .Reset(rst_n), .Start(start2), .B(b2),
    .Busy(busy2), .Done(done2), .R(r2)
  );

  pippenger_bucket_reduce #(.C(4)) dut4 (
    .clk(clk), .Reset(rst_n), .Start(start4), .B(b4),
    .Busy(busy4), .Done(done4), .R(r4)
  );

  // Counts cycles in which the C=2 instance pulses its adder start.
  always @(negedge clk) if (dut2.add_go) starts2++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic int fmod(input int a);
    return ((a % 251) + 251) % 251;
  endfunction

  function automatic int finv(input int a);
    int r, b, e;
    r = 1; b = fmod(a); e = 249;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % 251;
      b = (b * b) % 251;
      e = e / 2;
    end
    return r;
  endfunction

  function automatic curve_point_t ref_add(input curve_point_t p, input curve_point_t q);
    curve_point_t res;
    int x1, y1, x2, y2, lam, x3, y3;
    if (p.inf) return q;
    if (q.inf) return p;
    x1 = int'(p.x); y1 = int'(p.y); x2 = int'(q.x); y2 = int'(q.y);
    if (x1 == x2 && fmod(y1 + y2) == 0) return INF_POINT;
    if (x1 == x2) lam = fmod(fmod(3 * x1 * x1 + 2) * finv(2 * y1));
    else          lam = fmod(fmod(y2 - y1) * finv(x2 - x1));
    x3 = fmod(lam * lam - x1 - x2);
    y3 = fmod(lam * fmod(x1 - x3) - y1);
    res.inf = 1'b0; res.x = 8'(x3); res.y = 8'(y3);
    return res;
  endfunction

  function automatic curve_point_t ref_mul(input curve_point_t p, input int k);
    curve_point_t acc, add;
    int e;
    acc = INF_POINT; add = p; e = k;
    while (e > 0) begin
      if (e % 2 == 1) acc = ref_add(acc, add);
      add = ref_add(add, add);
      e = e / 2;
    end
    return acc;
  endfunction

  function automatic logic cur_done(input int which);
    return (which == 2) ? done2 : done4;
  endfunction

  function automatic logic cur_busy(input int which);
    return (which == 2) ? busy2 : busy4;
  endfunction

  function automatic curve_point_t cur_r(input int which);
    return (which == 2) ? r2 : r4;
  endfunction

  task automatic drive_start(input int which, input logic v);
    if (which == 2) start2 = v;
    else            start4 = v;
  endtask

  // One reduction: Start for one cycle, then watch Busy/R until Done.
  // pulse_at >= 0 re-asserts Start that many cycles into the run.
  task automatic applyStimulus(input int which, input int pulse_at,
                               output int cycles, output int busy_gap, output int r_changed,
                               output logic timed_out, output logic [1:0] first_db);
    curve_point_t r_before;
    cycles = 0; busy_gap = 0; r_changed = 0; timed_out = 1'b0;
    @(negedge clk);
    r_before = cur_r(which);
    drive_start(which, 1'b1);
    @(negedge clk);
    drive_start(which, 1'b0);
    first_db = {cur_done(which), cur_busy(which)};
    while (!cur_done(which) && !timed_out) begin
      if (!cur_busy(which)) busy_gap++;
      if (cur_r(which) !== r_before) r_changed++;
      drive_start(which, cycles == pulse_at);
      @(negedge clk);
      cycles++;
      if (cycles >= 3000) timed_out = 1'b1;
    end
    drive_start(which, 1'b0);
  endtask

  initial begin
    int cycles, gap, rchg, ord, ksum, kj;
    logic to, found;
    logic [1:0] fdb;
    curve_point_t cand, pt;

    rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0;
    for (int j = 1; j <= 3; j++)  b2[j] = INF_POINT;
    for (int j = 1; j <= 15; j++) b4[j] = INF_POINT;

    found = 1'b0;
    g = INF_POINT;
    for (int x = 0; x < 251 && !found; x++) begin
      for (int y = 1; y < 251 && !found; y++) begin
        if ((y * y) % 251 == fmod(x * x * x + 2 * x + 3)) begin
          cand.inf = 1'b0; cand.x = 8'(x); cand.y = 8'(y);
          pt = cand; ord = 1;
          while (!pt.inf && ord < 400) begin
            pt = ref_add(pt, cand);
            ord++;
          end
          if (ord >= 60) begin
            g = cand;
            found = 1'b1;
          end
        end
      end
    end
    $display("[TB] generator x=%0d y=%0d", g.x, g.y);

    repeat (2) @(negedge clk);
    checkOutput("rst_busy2", 64'(busy2), 64'(0));
    checkOutput("rst_done2", 64'(done2), 64'(0));
    checkOutput("rst_r2",    64'(r2),    64'(INF_POINT));
    checkOutput("rst_busy4", 64'(busy4), 64'(0));
    checkOutput("rst_done4", 64'(done4), 64'(0));
    checkOutput("rst_r4",    64'(r4),    64'(INF_POINT));
    rst_n = 1'b1;

    // All buckets empty: pure bypass, fixed 2*NB cycles.
    starts2 = 0;
    applyStimulus(2, -1, cycles, gap, rchg, to, fdb);
    checkOutput("inf_cycles", 64'(cycles),  64'(6));
    checkOutput("inf_r",      64'(r2),      64'(INF_POINT));
    checkOutput("inf_starts", 64'(starts2), 64'(0));
    checkOutput("inf_busy",   64'(gap),     64'(0));

    b2[1] = g;
    starts2 = 0;
    applyStimulus(2, -1, cycles, gap, rchg, to, fdb);
    checkOutput("g1_r",      64'(r2),      64'(ref_mul(g, 1)));
    checkOutput("g1_starts", 64'(starts2), 64'(0));
    checkOutput("g1_cycles", 64'(cycles),  64'(6));

    // Every bucket G: last sum step is 3G+3G, a doubling.
    for (int j = 1; j <= 3; j++) b2[j] = g;
    starts2 = 0;
    applyStimulus(2, -1, cycles, gap, rchg, to, fdb);
    checkOutput("g6_r",       64'(r2),      64'(ref_mul(g, 6)));
    checkOutput("g6_starts",  64'(starts2), 64'(4));
    checkOutput("g6_timeout", 64'(to),      64'(0));

    for (int it = 0; it < 3; it++) begin
      ksum = 0;
      for (int j = 1; j <= 15; j++) begin
        kj = int'($urandom_range(0, 30));
        b4[j] = ref_mul(g, kj);
        ksum += j * kj;
      end
      applyStimulus(4, -1, cycles, gap, rchg, to, fdb);
      checkOutput("rnd_r",       64'(r4),   64'(ref_mul(g, ksum)));
      checkOutput("rnd_busy",    64'(gap),  64'(0));
      checkOutput("rnd_r_held",  64'(rchg), 64'(0));
      checkOutput("rnd_timeout", 64'(to),   64'(0));
      @(negedge clk);
      checkOutput("rnd_done_level", 64'({done4, busy4}), 64'(2'b10));
    end

    // Asynchronous reset while an adder op is in flight.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (dut2.add_go) found = 1'b1;
    end
    checkOutput("rst_issue_seen", 64'(found), 64'(1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy2), 64'(0));
    checkOutput("midrst_done", 64'(done2), 64'(0));
    checkOutput("midrst_r",    64'(r2),    64'(INF_POINT));
    starts2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("postrst_starts", 64'(starts2), 64'(0));
    checkOutput("postrst_busy",   64'(busy2),   64'(0));
    applyStimulus(2, -1, cycles, gap, rchg, to, fdb);
    checkOutput("postrst_r", 64'(r2), 64'(ref_mul(g, 6)));

    // Start during Busy must neither restart nor stretch the run.
    b2[1] = g; b2[2] = INF_POINT; b2[3] = INF_POINT;
    applyStimulus(2, 3, cycles, gap, rchg, to, fdb);
    checkOutput("busy_start_cycles", 64'(cycles), 64'(6));
    checkOutput("busy_start_r",      64'(r2),     64'(ref_mul(g, 1)));
    checkOutput("busy_start_r_held", 64'(rchg),   64'(0));

    // Restart from DONE: Done drops at once, old R held until the new Done.
    for (int j = 1; j <= 3; j++) b2[j] = g;
    applyStimulus(2, -1, cycles, gap, rchg, to, fdb);
    checkOutput("restart_drop",   64'(fdb),  64'(2'b01));
    checkOutput("restart_r_held", 64'(rchg), 64'(0));
    checkOutput("restart_r",      64'(r2),   64'(ref_mul(g, 6)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pippenger_bucket_reduce.md
# pippenger_bucket_reduce

- Downstream stage of the Pippenger MSM bucket-fill step.
- For one scalar window, takes the filled bucket array B[1..2^C−1] and computes the window sum R = Σ j·B[j] with the running-sum method, using a single shared `point_add` instance.
- Its result feeds the window-combining (doubling/accumulate) logic of the MSM top level.

## Interface
Parameters:
- C, default 4: window width in bits. NB = 2^C − 1 buckets; bucket 0 is never read.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset; clears the FSM and outputs immediately when low.
- Start  input  1  request to reduce the current bucket array; sampled only in IDLE and DONE.
- B  input  curve_point_t [NB:1]  bucket sums. Caller holds them stable from the Start-sampling edge until Done.
- Busy  output  1  high while a reduction is in progress (RUN_ACC, RUN_SUM).
- Done  output  1  level; high in DONE until the next accepted Start or reset.
- R  output  curve_point_t  result; valid while Done=1, held in IDLE/DONE.

## Operation
- Registers:
  - j, C bits: bucket index.
  - acc, curve_point_t: running sum.
  - sum, curve_point_t: window sum.
- One `point_add` instance. Its Reset is driven internally as an active-high one-cycle start pulse; it holds P/Q and returns R plus a Done flag. It handles P==Q (doubling), P==−Q and inf_point operands.
- Algorithm: acc=inf_point, sum=inf_point; for j=NB down to 1: acc=acc+B[j]; sum=sum+acc. Then R=sum.
- States and transitions:
  - IDLE: Start=1 → load j=NB, acc=inf_point, sum=inf_point; go to RUN_ACC.
  - RUN_ACC: compute acc+B[j], then go to RUN_SUM.
  - RUN_SUM: compute sum+acc. If j==1, R←result and go to DONE; else j←j−1 and go to RUN_ACC.
  - DONE: Done=1. Start=1 restarts exactly as from IDLE. No transition back to IDLE except by reset.
- Each addition step is one of two kinds:
  - Bypass: if either operand equals inf_point, the result is the other operand. It is written in one cycle and the adder is not started.
  - Adder op: on the issue cycle, pulse adder Reset=1 with operands applied. Hold operands stable. Wait in the same state until adder Done=1 is sampled, no earlier than the cycle after issue. Capture the result on that edge and advance.
- Start while Busy=1 is ignored; no queueing.
- Buckets are not modified; B[0] is never referenced.

## Timing
- Reset values (asynchronous, Reset=0): state=IDLE, Busy=0, Done=0, R=inf_point, acc=sum=inf_point, j=NB, adder Reset=0.
- Start accepted at edge T0 → Busy=1 from T0.
- A bypass step takes 1 cycle. An adder step takes 1 + L_add cycles, where L_add is the `point_add` latency from start pulse to Done.
- Total cycles = 2·NB steps. Done rises and Busy falls on the edge that completes the last step (edge T0 + Σ step cycles).
- Best case (all buckets inf_point): Done at T0 + 2·NB.
- R updates only on entry to DONE. It is never written mid-reduction, so the previous result is visible until then.
- Reset low mid-reduction: immediate return to reset values. The adder result in flight is discarded and the adder is not started again until the next Start.
- Restart from DONE: Done falls and Busy rises on the Start-sampling edge.

## Test plan
- C=2, all B=inf_point, Start 1 cycle → Done after exactly 6 cycles, R=inf_point, adder never started (adder Reset never 1).
- C=2, B[1]=G, B[2]=B[3]=inf_point → R=G, matches `point_mul_double_and_add`(G,1); exactly 0 adder starts.
- C=2, B[1]=B[2]=B[3]=G → R=6G (checked against point_mul with k=6); doubling path exercised (sum+acc with equal operands).
- C=4, random B[j]=k_j·G for random k_j → R equals point_mul(G, Σ j·k_j mod n). Busy=1 for the full duration, Done a single clean rise.
- Reset driven low 3 cycles into an adder op, with C=2 and B all G → Busy/Done/R return to reset values in the same cycle. A following Start then yields R=6G.
- Start pulsed during Busy → ignored, result unchanged. Start in DONE → Done drops next edge and the new result replaces R only at the new Done.
